// File: rtl/usertype.sv
// usertype: shared FSM state encoding and default DRAM base address for the AXI-Lite bridge.
package usertype;
   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP,
      DONE
   } state_t;
   localparam logic [16:0] BASE_ADDR_DEFAULT = 17'h10000;
endpackage

// File: rtl/bridge_axi_lite.sv
// bridge_axi_lite: turns single-record read/write requests into AXI-Lite transactions
// and returns a one-cycle completion strobe with the read data.
module bridge_axi_lite
   import usertype::*;
#(
   parameter logic [16:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        C_in_valid,
   input  logic        C_r_wb,
   input  logic [7:0]  C_addr,
   input  logic [63:0] C_data_w,
   output logic        C_out_valid,
   output logic [63:0] C_data_r,
   output logic        AR_VALID,
   input  logic        AR_READY,
   output logic [16:0] AR_ADDR,
   input  logic        R_VALID,
   output logic        R_READY,
   input  logic [63:0] R_DATA,
   input  logic [1:0]  R_RESP,
   output logic        AW_VALID,
   input  logic        AW_READY,
   output logic [16:0] AW_ADDR,
   output logic        W_VALID,
   input  logic        W_READY,
   output logic [63:0] W_DATA,
   input  logic        B_VALID,
   output logic        B_READY,
   input  logic [1:0]  B_RESP
);
   state_t      r_state, w_next;
   logic        r_rwb;
   logic [7:0]  r_addr;
   logic [63:0] r_wdata;
   logic        r_ar_valid, r_r_ready, r_aw_valid, r_w_valid, r_b_ready;
   logic        r_aw_done, r_w_done, r_out_valid;
   logic [16:0] r_ar_addr, r_aw_addr;
   logic [63:0] r_w_data, r_data_r;
   logic        w_start, w_ar_hs, w_r_hs, w_b_hs, w_aw_ok, w_w_ok, w_aw_next, w_w_next;
   logic [7:0]  w_sel_addr;
   logic [16:0] w_addr;
   logic        w_unused_resp;
   assign w_unused_resp = ^{R_RESP, B_RESP};
   assign w_start    = (r_state == IDLE) && C_in_valid;
   assign w_ar_hs    = r_ar_valid && AR_READY;
   assign w_r_hs     = r_r_ready && R_VALID;
   assign w_b_hs     = r_b_ready && B_VALID;
   assign w_aw_ok    = r_aw_done || (r_aw_valid && AW_READY);
   assign w_w_ok     = r_w_done || (r_w_valid && W_READY);
   // On the accepting cycle the request fields are not latched yet, so use them directly.
   assign w_sel_addr = w_start ? C_addr : r_addr;
   assign w_addr     = BASE_ADDR + {6'd0, w_sel_addr, 3'd0};
   assign w_aw_next  = (w_start && !C_r_wb) || (r_aw_valid && !AW_READY);
   assign w_w_next   = (w_start && !C_r_wb) || (r_w_valid && !W_READY);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (C_in_valid) w_next = C_r_wb ? RD_ADDR : WR_REQ;
         RD_ADDR: if (w_ar_hs) w_next = RD_DATA;
         RD_DATA: if (w_r_hs) w_next = DONE;
         WR_REQ:  if (w_aw_ok && w_w_ok) w_next = WR_RESP;
         WR_RESP: if (w_b_hs) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rwb       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_ar_valid  <= 1'b0;
         r_ar_addr   <= '0;
         r_r_ready   <= 1'b0;
         r_aw_valid  <= 1'b0;
         r_aw_addr   <= '0;
         r_w_valid   <= 1'b0;
         r_w_data    <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_b_ready   <= 1'b0;
         r_out_valid <= 1'b0;
         r_data_r    <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_rwb   <= C_r_wb;
            r_addr  <= C_addr;
            r_wdata <= C_data_w;
         end
         r_ar_valid  <= w_next == RD_ADDR;
         r_ar_addr   <= (w_next == RD_ADDR) ? w_addr : '0;
         // READY is registered off the state, so it appears from the second cycle of the data phase.
         r_r_ready   <= (r_state == RD_DATA) && (w_next == RD_DATA);
         r_aw_valid  <= w_aw_next;
         r_aw_addr   <= w_aw_next ? w_addr : '0;
         r_w_valid   <= w_w_next;
         r_w_data    <= w_w_next ? (w_start ? C_data_w : r_wdata) : '0;
         r_aw_done   <= (r_state == WR_REQ) && (w_next == WR_REQ) && w_aw_ok;
         r_w_done    <= (r_state == WR_REQ) && (w_next == WR_REQ) && w_w_ok;
         r_b_ready   <= (r_state == WR_RESP) && (w_next == WR_RESP);
         r_out_valid <= w_next == DONE;
         r_data_r    <= (w_r_hs && r_rwb) ? R_DATA : '0;
      end
   end
   assign C_out_valid = r_out_valid;
   assign C_data_r    = r_data_r;
   assign AR_VALID    = r_ar_valid;
   assign AR_ADDR     = r_ar_addr;
   assign R_READY     = r_r_ready;
   assign AW_VALID    = r_aw_valid;
   assign AW_ADDR     = r_aw_addr;
   assign W_VALID     = r_w_valid;
   assign W_DATA      = r_w_data;
   assign B_READY     = r_b_ready;
endmodule

// File: tb/tb_bridge_axi_lite.sv
// tb_bridge_axi_lite: directed and random record reads/writes against a cycle-level DRAM
// responder, with expected addresses, latencies and data computed from the bridge's rules.
module tb_bridge_axi_lite;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        C_in_valid = 1'b0, C_r_wb = 1'b0;
   logic [7:0]  C_addr = '0;
   logic [63:0] C_data_w = '0;
   logic        C_out_valid;
   logic [63:0] C_data_r;
   logic        AR_VALID, AR_READY = 1'b0;
   logic [16:0] AR_ADDR;
   logic        R_VALID = 1'b0, R_READY;
   logic [63:0] R_DATA = '0;
   logic [1:0]  R_RESP = '0;
   logic        AW_VALID, AW_READY = 1'b0;
   logic [16:0] AW_ADDR;
   logic        W_VALID, W_READY = 1'b0;
   logic [63:0] W_DATA;
   logic        B_VALID = 1'b0, B_READY;
   logic [1:0]  B_RESP = '0;
   int n_cmp = 0;
   int n_bad = 0;
   bridge_axi_lite dut (
      .clk(clk), .rst(rst),
      .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
      .C_out_valid(C_out_valid), .C_data_r(C_data_r),
      .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
      .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
      .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
      .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
      .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [63:0] all_outs_or();
      return 64'(|{C_out_valid, C_data_r, AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR,
                   W_VALID, W_DATA, B_READY});
   endfunction
   // One request; the responder raises READY after the given number of VALID cycles and
   // presents R_VALID/B_VALID a given number of cycles after the preceding phase finished.
   task automatic txn(input bit rwb, input logic [7:0] a, input logic [63:0] wd,
                      input logic [63:0] rd, input int ard, input int rdd, input int awd,
                      input int wdd, input int bd, input int pulse_at, input int rst_at,
                      input int resp);
      int ea, exp_lat, lat, n_out, ar_seen, aw_seen, w_seen, ar_c, aw_c, w_c, m;
      bit r_done, b_done, fin, bad_hs, bad_addr, bad_idle, bad_rdy;
      logic [63:0] got;
      ea = (32'h10000 + int'(a) * 8) % 131072;
      exp_lat = rwb ? 4 + ard + (rdd > 0 ? rdd - 1 : 0)
                    : 4 + (awd > wdd ? awd : wdd) + (bd > 0 ? bd - 1 : 0);
      {lat, n_out, ar_seen, aw_seen, w_seen, ar_c, aw_c, w_c, m} = '0;
      {r_done, b_done, fin, bad_hs, bad_addr, bad_idle, bad_rdy} = '0;
      got = '0;
      C_in_valid = 1'b1; C_r_wb = rwb; C_addr = a; C_data_w = wd;
      AR_READY = 1'b0; R_VALID = 1'b0; AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0;
      for (int cyc = 1; cyc <= 80 && !fin; cyc++) begin
         @(negedge clk);
         if (rst_at > 0 && cyc == rst_at + 1) begin
            chk("rst_mid_outs", all_outs_or(), 64'd0);
            chk("rst_mid_no_done", 64'(n_out), 64'd0);
            rst = 1'b0;
            fin = 1'b1;
         end else begin
            m = aw_c > w_c ? aw_c : w_c;
            if (C_out_valid) begin
               n_out++;
               lat = cyc;
               got = C_data_r;
            end else if (C_data_r !== '0) bad_idle = 1'b1;
            if (AR_VALID !== (rwb && ar_c == 0)) bad_hs = 1'b1;
            if (AW_VALID !== (!rwb && aw_c == 0)) bad_hs = 1'b1;
            if (W_VALID !== (!rwb && w_c == 0)) bad_hs = 1'b1;
            if (AR_ADDR !== (AR_VALID ? 17'(ea) : 17'd0)) bad_addr = 1'b1;
            if (AW_ADDR !== (AW_VALID ? 17'(ea) : 17'd0)) bad_addr = 1'b1;
            if (W_DATA !== (W_VALID ? wd : 64'd0)) bad_addr = 1'b1;
            if (R_READY !== (rwb && ar_c > 0 && cyc >= ar_c + 2 && !r_done)) bad_rdy = 1'b1;
            if (B_READY !== (!rwb && aw_c > 0 && w_c > 0 && cyc >= m + 2 && !b_done)) bad_rdy = 1'b1;
            if (lat > 0 && cyc == lat + 1) begin
               C_in_valid = 1'b0;
               fin = 1'b1;
            end else begin
               C_in_valid = (cyc == pulse_at);
               C_r_wb = 1'($urandom);
               C_addr = 8'($urandom);
               C_data_w = {$urandom, $urandom};
               if (AR_VALID) ar_seen++;
               AR_READY = AR_VALID ? (ar_seen - 1 >= ard) : 1'($urandom);
               if (AR_VALID && AR_READY) ar_c = cyc;
               R_VALID = rwb && ar_c > 0 && cyc >= ar_c + 1 + rdd && !r_done;
               R_DATA = R_VALID ? rd : {$urandom, $urandom};
               R_RESP = resp >= 0 ? 2'(resp) : 2'($urandom);
               if (R_VALID && R_READY) r_done = 1'b1;
               if (AW_VALID) aw_seen++;
               if (W_VALID) w_seen++;
               AW_READY = AW_VALID ? (aw_seen - 1 >= awd) : 1'($urandom);
               W_READY = W_VALID ? (w_seen - 1 >= wdd) : 1'($urandom);
               if (AW_VALID && AW_READY) aw_c = cyc;
               if (W_VALID && W_READY) w_c = cyc;
               m = aw_c > w_c ? aw_c : w_c;
               B_VALID = !rwb && aw_c > 0 && w_c > 0 && cyc >= m + 1 + bd && !b_done;
               B_RESP = resp >= 0 ? 2'(resp) : 2'($urandom);
               if (B_VALID && B_READY) b_done = 1'b1;
               if (rst_at > 0 && cyc == rst_at) rst = 1'b1;
            end
         end
      end
      if (rst_at == 0) begin
         chk($sformatf("latency a=%h rw=%0d", a, rwb), 64'(lat), 64'(exp_lat));
         chk($sformatf("done_count a=%h", a), 64'(n_out), 64'd1);
         chk($sformatf("data_r a=%h rw=%0d", a, rwb), got, rwb ? rd : 64'd0);
         chk($sformatf("idle_data_r a=%h", a), 64'(bad_idle), 64'd0);
         chk($sformatf("ready_timing a=%h", a), 64'(bad_rdy), 64'd0);
      end
      chk($sformatf("valid_seq a=%h rw=%0d", a, rwb), 64'(bad_hs), 64'd0);
      chk($sformatf("addr_wdata a=%h", a), 64'(bad_addr), 64'd0);
   endtask
   initial begin
      bit          rw;
      logic [7:0]  a;
      logic [63:0] wd, rd;
      repeat (3) @(negedge clk);
      chk("reset_outs", all_outs_or(), 64'd0);
      rst = 1'b0;
      txn(1'b1, 8'h05, 64'd0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0, 0, 0, 0, -1);
      txn(1'b0, 8'hFF, 64'h1, 64'd0, 0, 0, 3, 0, 0, 0, 0, -1);
      txn(1'b1, 8'h3C, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 3, 0, 0, 0, 3, 0, -1);
      txn(1'b1, 8'hA0, 64'd0, 64'hFEED_FACE_CAFE_0001, 10, 0, 0, 0, 0, 0, 0, -1);
      txn(1'b0, 8'h11, 64'h5555_AAAA_5555_AAAA, 64'd0, 0, 0, 0, 0, 10, 0, 4, -1);
      txn(1'b1, 8'h22, 64'd0, 64'h1111_2222_3333_4444, 0, 0, 0, 0, 0, 0, 0, -1);
      txn(1'b1, 8'h33, 64'd0, 64'h9999_8888_7777_6666, 1, 2, 0, 0, 0, 0, 0, 2);
      txn(1'b0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 0, 2, 2, 0, 0, 2);
      for (int k = 0; k < 40; k++) begin
         rw = 1'($urandom);
         a = 8'($urandom);
         wd = {$urandom, $urandom};
         rd = {$urandom, $urandom};
         txn(rw, a, wd, rd, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 0, -1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
